// File: rtl/matrix_mac_array.sv
// matrix_mac_array: C = A*B (+ Cin), M parallel MAC lanes stepping one column of C at a time.
// Operands are captured on accept; the stb/ack handshake matches the legacy fixed multiplier.
module matrix_mac_array #(
  parameter int unsigned M = 4,
  parameter int unsigned P = 4,
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:M*P*W-1]     matrix_A,
  input  logic [0:P*N*W-1]     matrix_B,
  input  logic [0:M*N*W-1]     matrix_Cin,
  input  logic                 acc_en,
  input  logic                 a_stb,
  input  logic                 b_stb,
  output logic                 a_ack,
  output logic                 b_ack,
  output logic [0:M*N*W-1]     matrix_C,
  output logic                 c_stb,
  input  logic                 c_ack,
  output logic                 busy
);

  localparam int unsigned KW = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned JW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(P - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_a   [M][P];
  logic [W-1:0]   r_b   [P][N];
  logic [W-1:0]   r_cin [M][N];
  logic [W-1:0]   r_c   [M][N];
  logic [W-1:0]   r_acc [M];
  logic           r_acc_en;
  logic [KW-1:0]  r_k;
  logic [JW-1:0]  r_j;
  logic           r_a_ack;
  logic           r_b_ack;
  logic           r_c_stb;
  logic           r_busy;

  logic [W-1:0]   w_sum [M];
  logic [JW-1:0]  w_j_nxt;

  // Per-lane running sum including this cycle's product, and the next column index
  always_comb begin
    w_j_nxt = (r_j == J_LAST) ? '0 : r_j + JW'(1);
    for (int r = 0; r < M; r++) begin
      w_sum[r] = r_acc[r] + r_a[r][r_k] * r_b[r_k][r_j];
    end
  end

  // Control FSM, operand buffers, lane accumulators and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_acc_en <= 1'b0;
      r_k      <= '0;
      r_j      <= '0;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      r_c_stb  <= 1'b0;
      r_busy   <= 1'b0;
      for (int r = 0; r < M; r++) begin
        r_acc[r] <= '0;
        for (int k = 0; k < P; k++) r_a[r][k] <= '0;
        for (int c = 0; c < N; c++) begin
          r_cin[r][c] <= '0;
          r_c[r][c]   <= '0;
        end
      end
      for (int k = 0; k < P; k++) begin
        for (int c = 0; c < N; c++) r_b[k][c] <= '0;
      end
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (a_stb && b_stb) begin
            for (int r = 0; r < M; r++) begin
              for (int k = 0; k < P; k++) r_a[r][k] <= matrix_A[(r*P + k)*W +: W];
              for (int c = 0; c < N; c++) r_cin[r][c] <= matrix_Cin[(r*N + c)*W +: W];
              r_acc[r] <= acc_en ? matrix_Cin[(r*N)*W +: W] : '0;
            end
            for (int k = 0; k < P; k++) begin
              for (int c = 0; c < N; c++) r_b[k][c] <= matrix_B[(k*N + c)*W +: W];
            end
            r_acc_en <= acc_en;
            r_k      <= '0;
            r_j      <= '0;
            r_a_ack  <= 1'b1;
            r_b_ack  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_k == K_LAST) begin
            // Column finished: publish it and preload the addend for the next column
            for (int r = 0; r < M; r++) begin
              r_c[r][r_j] <= w_sum[r];
              r_acc[r]    <= r_acc_en ? r_cin[r][w_j_nxt] : '0;
            end
            r_k <= '0;
            r_j <= w_j_nxt;
            if (r_j == J_LAST) begin
              r_c_stb <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            for (int r = 0; r < M; r++) r_acc[r] <= w_sum[r];
            r_k <= r_k + KW'(1);
          end
        end
        S_DONE: begin
          if (c_ack) begin
            r_c_stb <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Flatten the result registers onto the row-major output bus
  always_comb begin
    matrix_C = '0;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) matrix_C[(r*N + c)*W +: W] = r_c[r][c];
    end
  end

  assign a_ack = r_a_ack;
  assign b_ack = r_b_ack;
  assign c_stb = r_c_stb;
  assign busy  = r_busy;

endmodule

// File: tb/tb_matrix_mac_array.sv
// Scoreboard bench for matrix_mac_array: three configurations, directed vectors.
module tb_matrix_mac_array;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: M=P=N=2, W=8
  logic [0:31] a0 = '0, b0 = '0, cin0 = '0;
  logic [0:31] c0;
  logic acc0 = 1'b0, as0 = 1'b0, bs0 = 1'b0, ca0 = 1'b1;
  logic aa0, ba0, cs0, busy0;

  // Instance 1: M=2, P=3, N=4, W=16
  logic [0:95]  a1 = '0;
  logic [0:191] b1 = '0;
  logic [0:127] cin1 = '0;
  logic [0:127] c1;
  logic acc1 = 1'b0, as1 = 1'b0, bs1 = 1'b0, ca1 = 1'b1;
  logic aa1, ba1, cs1, busy1;

  // Instance 2: M=1, P=2, N=1, W=8
  logic [0:15] a2 = '0, b2 = '0;
  logic [0:7]  cin2 = '0;
  logic [0:7]  c2;
  logic acc2 = 1'b0, as2 = 1'b0, bs2 = 1'b0, ca2 = 1'b1;
  logic aa2, ba2, cs2, busy2;

  matrix_mac_array #(.M(2), .P(2), .N(2), .W(8)) u_dut0 (
    .clk(clk), .rst(rst), .matrix_A(a0), .matrix_B(b0), .matrix_Cin(cin0),
    .acc_en(acc0), .a_stb(as0), .b_stb(bs0), .a_ack(aa0), .b_ack(ba0),
    .matrix_C(c0), .c_stb(cs0), .c_ack(ca0), .busy(busy0));

  matrix_mac_array #(.M(2), .P(3), .N(4), .W(16)) u_dut1 (
    .clk(clk), .rst(rst), .matrix_A(a1), .matrix_B(b1), .matrix_Cin(cin1),
    .acc_en(acc1), .a_stb(as1), .b_stb(bs1), .a_ack(aa1), .b_ack(ba1),
    .matrix_C(c1), .c_stb(cs1), .c_ack(ca1), .busy(busy1));

  matrix_mac_array #(.M(1), .P(2), .N(1), .W(8)) u_dut2 (
    .clk(clk), .rst(rst), .matrix_A(a2), .matrix_B(b2), .matrix_Cin(cin2),
    .acc_en(acc2), .a_stb(as2), .b_stb(bs2), .a_ack(aa2), .b_ack(ba2),
    .matrix_C(c2), .c_stb(cs2), .c_ack(ca2), .busy(busy2));

  // Expected results and the cycle on which c_stb must first be seen
  logic [0:31]  q0_d[$];
  int           q0_c[$];
  logic [0:127] q1_d[$];
  int           q1_c[$];
  logic [0:7]   q2_d[$];
  int           q2_c[$];
  logic cs0_q = 1'b0, cs1_q = 1'b0, cs2_q = 1'b0;
  logic [0:31]  e0;
  logic [0:127] e1;
  logic [0:7]   e2;
  int           ec0, ec1, ec2;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitors: on each rising c_stb pop the oldest expectation and compare data and latency
  always @(negedge clk) begin
    if (cs0 && !cs0_q) begin
      if (q0_d.size() == 0) chk("c0_unexpected_stb", cs0, 0);
      else begin
        e0 = q0_d.pop_front(); ec0 = q0_c.pop_front();
        chk("c0_data", c0, e0);
        chk("c0_latency", cyc, ec0);
      end
    end
    cs0_q <= cs0;
  end

  always @(negedge clk) begin
    if (cs1 && !cs1_q) begin
      if (q1_d.size() == 0) chk("c1_unexpected_stb", cs1, 0);
      else begin
        e1 = q1_d.pop_front(); ec1 = q1_c.pop_front();
        chk("c1_data", c1, e1);
        chk("c1_latency", cyc, ec1);
      end
    end
    cs1_q <= cs1;
  end

  always @(negedge clk) begin
    if (cs2 && !cs2_q) begin
      if (q2_d.size() == 0) chk("c2_unexpected_stb", cs2, 0);
      else begin
        e2 = q2_d.pop_front(); ec2 = q2_c.pop_front();
        chk("c2_data", c2, e2);
        chk("c2_latency", cyc, ec2);
      end
    end
    cs2_q <= cs2;
  end

  task automatic wait_idle(input int id, input string nm);
    logic b;
    for (int i = 0; i < 60; i++) begin
      b = (id == 0) ? busy0 : (id == 1) ? busy1 : busy2;
      if (!b) return;
      @(negedge clk);
    end
    chk(nm, b, 0);
  endtask

  task automatic op0(input logic [0:31] a, input logic [0:31] b, input logic [0:31] cin,
                     input logic acc, input logic [0:31] exp, input bit wait_done);
    @(negedge clk);
    a0 = a; b0 = b; cin0 = cin; acc0 = acc; as0 = 1'b1; bs0 = 1'b1;
    q0_d.push_back(exp); q0_c.push_back(cyc + 1 + 4);
    @(negedge clk);
    as0 = 1'b0; bs0 = 1'b0;
    a0 = $urandom; b0 = $urandom; cin0 = $urandom; acc0 = ~acc;
    chk("op0_acks_high", {aa0, ba0, busy0}, 3'b111);
    @(negedge clk);
    chk("op0_acks_low", {aa0, ba0}, 2'b00);
    if (wait_done) wait_idle(0, "op0_timeout");
  endtask

  task automatic op1(input logic [0:95] a, input logic [0:191] b, input logic [0:127] cin,
                     input logic acc, input logic [0:127] exp, input bit wait_done);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = cin; acc1 = acc; as1 = 1'b1; bs1 = 1'b1;
    q1_d.push_back(exp); q1_c.push_back(cyc + 1 + 12);
    @(negedge clk);
    as1 = 1'b0; bs1 = 1'b0;
    a1 = {3{$urandom}}; b1 = {6{$urandom}}; cin1 = {4{$urandom}}; acc1 = ~acc;
    chk("op1_acks_high", {aa1, ba1, busy1}, 3'b111);
    @(negedge clk);
    chk("op1_acks_low", {aa1, ba1}, 2'b00);
    if (wait_done) wait_idle(1, "op1_timeout");
  endtask

  task automatic op2(input logic [0:15] a, input logic [0:15] b, input logic [0:7] cin,
                     input logic acc, input logic [0:7] exp);
    @(negedge clk);
    a2 = a; b2 = b; cin2 = cin; acc2 = acc; as2 = 1'b1; bs2 = 1'b1;
    q2_d.push_back(exp); q2_c.push_back(cyc + 1 + 2);
    @(negedge clk);
    as2 = 1'b0; bs2 = 1'b0; a2 = 16'h0; b2 = 16'h0; cin2 = 8'h0;
    chk("op2_acks_high", {aa2, ba2}, 2'b11);
    wait_idle(2, "op2_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl0", {aa0, ba0, cs0, busy0}, 4'b0);
    chk("rst_c0", c0, 0);
    chk("rst_c1", c1, 0);
    chk("rst_ctrl2", {aa2, ba2, cs2, busy2}, 4'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Identity, addend ignored with acc_en=0
    op0({8'd1, 8'd2, 8'd3, 8'd4}, {8'd1, 8'd0, 8'd0, 8'd1}, {4{8'd9}}, 1'b0,
        {8'd1, 8'd2, 8'd3, 8'd4}, 1'b1);
    // Accumulate on and off with the same addend
    op0({4{8'd1}}, {4{8'd1}}, {8'd10, 8'd20, 8'd30, 8'd40}, 1'b1,
        {8'd12, 8'd22, 8'd32, 8'd42}, 1'b1);
    op0({4{8'd1}}, {4{8'd1}}, {8'd10, 8'd20, 8'd30, 8'd40}, 1'b0,
        {4{8'd2}}, 1'b1);

    // Handshake: lone a_stb must not be accepted
    @(negedge clk);
    ca0 = 1'b0; a0 = {8'd1, 8'd2, 8'd3, 8'd4}; b0 = {8'd5, 8'd6, 8'd7, 8'd8};
    cin0 = '0; acc0 = 1'b0; as0 = 1'b1; bs0 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hs_lone_a", {aa0, ba0, busy0}, 3'b000);
    end
    bs0 = 1'b1;
    q0_d.push_back({8'd19, 8'd22, 8'd43, 8'd50}); q0_c.push_back(cyc + 1 + 4);
    @(negedge clk);
    as0 = 1'b0; bs0 = 1'b0;
    chk("hs_acks", {aa0, ba0}, 2'b11);
    for (int i = 0; i < 20; i++) begin
      if (cs0) break;
      @(negedge clk);
    end
    chk("hs_cstb_up", cs0, 1);
    // c_ack held low: result must stay presented and stable
    repeat (10) begin
      @(negedge clk);
      chk("hs_cstb_hold", cs0, 1);
      chk("hs_c_hold", c0, {8'd19, 8'd22, 8'd43, 8'd50});
    end
    // Ack together with a new request: the request must wait for the edge after the ack
    ca0 = 1'b1; as0 = 1'b1; bs0 = 1'b1;
    a0 = {4{8'd1}}; b0 = {8'd1, 8'd2, 8'd3, 8'd4};
    @(negedge clk);
    chk("hs_after_ack", {cs0, busy0, aa0, ba0}, 4'b0);
    chk("hs_c_kept", c0, {8'd19, 8'd22, 8'd43, 8'd50});
    q0_d.push_back({8'd4, 8'd6, 8'd4, 8'd6}); q0_c.push_back(cyc + 1 + 4);
    @(negedge clk);
    as0 = 1'b0; bs0 = 1'b0;
    chk("hs_back_to_back", {aa0, ba0, busy0}, 3'b111);
    wait_idle(0, "hs_timeout");

    // Reset in the middle of CALC discards the operation
    @(negedge clk);
    a0 = {8'd1, 8'd2, 8'd3, 8'd4}; b0 = {8'd5, 8'd6, 8'd7, 8'd8}; as0 = 1'b1; bs0 = 1'b1;
    @(negedge clk);
    as0 = 1'b0; bs0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ctrl", {aa0, ba0, cs0, busy0}, 4'b0);
    chk("rst_mid_c", c0, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_result", {cs0, busy0}, 2'b00);
    end
    op0({8'd2, 8'd3, 8'd4, 8'd5}, {4{8'd1}}, '0, 1'b0,
        {8'd5, 8'd5, 8'd9, 8'd9}, 1'b1);

    // Non-square 2x3 * 3x4, W=16, including a wrapped -1 operand
    op1({16'hFFFF, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6},
        {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12},
        '0, 1'b0,
        {16'd36, 16'd40, 16'd44, 16'd48, 16'd83, 16'd98, 16'd113, 16'd128}, 1'b0);
    // Column 0 lands after edge T0+3, column 1 not yet
    @(negedge clk);
    chk("col0_early", c1[0 +: 16], 0);
    @(negedge clk);
    chk("col0_r0", c1[0 +: 16], 16'd36);
    chk("col0_r1", c1[64 +: 16], 16'd83);
    chk("col1_pending", c1[16 +: 16], 0);
    wait_idle(1, "op1_timeout");
    op1({16'hFFFF, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6},
        {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12},
        {16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600, 16'd700, 16'd800}, 1'b1,
        {16'd136, 16'd240, 16'd344, 16'd448, 16'd583, 16'd698, 16'd813, 16'd928}, 1'b1);

    // Modulo 2^8 wrap
    op2({8'd255, 8'd255}, {8'd2, 8'd3}, 8'd0, 1'b0, 8'd251);
    op2({8'd255, 8'd255}, {8'd2, 8'd3}, 8'd10, 1'b1, 8'd5);

    repeat (5) @(negedge clk);
    chk("q0_drained", q0_d.size(), 0);
    chk("q1_drained", q1_d.size(), 0);
    chk("q2_drained", q2_d.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_mac_array.md
# matrix_mac_array

Parametrised successor to the existing matrix multiplier. Computes C = A·B, or C = A·B + C_in in accumulate mode, for A (M×P), B (P×N) and C (M×N) with a configurable word width. M parallel multiply-accumulate lanes step through one column of C at a time. It uses the same stb/ack handshake on each operand and result port, so it drops into the existing datapath in place of the fixed 32-bit multiplier.

## Interface
- M, 4: rows of A and C; number of MAC lanes (≥1)
- P, 4: columns of A and rows of B; inner-product length (≥1)
- N, 4: columns of B and C (≥1)
- W, 32: element word width in bits (≥2)
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- matrix_A  input  M·P·W  row-major; element (r,k) at bits [(r·P+k)·W +: W], vector declared [0:M·P·W-1]
- matrix_B  input  P·N·W  row-major; element (k,c) at [(k·N+c)·W +: W]
- matrix_Cin  input  M·N·W  row-major addend, used only when acc_en=1
- acc_en  input  1  accumulate mode, sampled at accept
- a_stb  input  1  A (and Cin) valid
- b_stb  input  1  B valid
- a_ack  output  1  A/Cin captured (one-cycle pulse)
- b_ack  output  1  B captured (one-cycle pulse)
- matrix_C  output  M·N·W  row-major result; element (r,c) at [(r·N+c)·W +: W]
- c_stb  output  1  matrix_C valid
- c_ack  input  1  consumer has taken matrix_C
- busy  output  1  high in CALC and DONE

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE: on a clk edge with a_stb=1 and b_stb=1:
  - register matrix_A, matrix_B, matrix_Cin and acc_en into internal operand buffers;
  - clear counters k=0 and j=0;
  - load each lane accumulator with Cin(r,0) if acc_en, else 0;
  - go to CALC.
  - With only one of the two stb signals high, nothing is captured and neither ack is asserted.
- CALC: each cycle lane r computes acc_r += A(r,k)·B(k,j).
  - When k=P-1: write acc_r + the final product to matrix_C(r,j) for every r; reset k to 0; increment j; reload acc_r with Cin(r,j+1) or 0.
  - Otherwise increment k.
  - When k=P-1 and j=N-1, go to DONE instead.
- DONE: c_stb=1 and matrix_C is held stable. On an edge with c_ack=1, go to IDLE.
- Arithmetic: each output element equals the exact sum modulo 2^W (low W bits). Results are identical for signed and unsigned interpretation.
  - Products and accumulators may be kept at W bits; wider internal precision is allowed, but only the low W bits are output.
- Input ports are not re-read after accept. Producers may change A, B or Cin freely during CALC and DONE.
- a_stb and b_stb are ignored in CALC and DONE. c_ack is ignored outside DONE.

## Timing
- Reset values: a_ack=0, b_ack=0, c_stb=0, busy=0, matrix_C all zero, state=IDLE, counters 0.
- Reset is asynchronous. Asserting it mid-CALC or mid-DONE aborts the operation: the result is discarded and no c_stb is produced.
- Accept edge T0: a_ack and b_ack are 1 for exactly the cycle after T0, then 0. busy rises after T0.
- CALC lasts exactly N·P cycles. c_stb rises after edge T0+N·P, giving total latency N·P+1 edges from accept to c_stb.
- Column j of matrix_C updates after edge T0+(j+1)·P. Consumers must treat matrix_C as valid only while c_stb=1.
- c_stb stays high until the first edge with c_ack=1. c_stb and busy fall after that edge, and matrix_C keeps its value.
- The next accept can occur on the edge immediately after the c_ack edge. Minimum period between results is N·P+2 cycles.
- With c_ack tied high, c_stb is a one-cycle pulse.
- Degenerate case P=1: one cycle per column.
- Degenerate case M=N=P=1: c_stb rises 2 edges after accept.

## Test plan
- Identity, M=P=N=2, W=8: A=[[1,2],[3,4]], B=I, acc_en=0 -> C=[[1,2],[3,4]]. c_stb rises 5 edges after accept; a_ack and b_ack each pulse for 1 cycle.
- Non-square, M=2, P=3, N=4, W=16, random values -> C matches the reference model mod 2^16, written row-major with N stride. Latency 13.
- Wrap, W=8: A=[[255,255]], B=[[2],[3]] -> C=[[251]] (1275 mod 256).
- Accumulate, 2×2×2: A=B=all ones, Cin=[[10,20],[30,40]], acc_en=1 -> C=[[12,22],[32,42]]. Repeating with acc_en=0 and the same Cin -> all 2.
- Handshake: only a_stb high for 5 cycles -> no acks and busy=0. Then b_stb rises -> accept. c_ack held low for 10 cycles -> c_stb and matrix_C stable. Next operation is accepted on the edge after the c_ack edge.
- Reset mid-CALC (pull rst low at cycle 3) -> all outputs return to reset values immediately. After release, a new operation completes correctly with the counters starting at 0.
